// File: rtl/gp_pkg.sv
// Shared definitions for the graphics command front end and decoder.
package gp_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } gp_state_e;

  localparam logic [7:0]  STOP_OP_DEFAULT  = 8'h00;
  localparam logic [31:0] FRAME_RESET_BASE = 32'h1F80_0000;

  // Opcode field of a command word, shared with the command decoder.
  localparam int unsigned CMD_OP_MSB = 31;
  localparam int unsigned CMD_OP_LSB = 24;
  localparam int unsigned CMD_OP_W   = CMD_OP_MSB - CMD_OP_LSB + 1;

  function automatic logic [CMD_OP_W-1:0] cmd_opcode(input logic [31:0] cmd);
    return cmd[CMD_OP_MSB:CMD_OP_LSB];
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/gp_cmd_fifo.sv
// Synchronous FIFO with registered storage and an occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module gp_cmd_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q;
  logic [AddrW-1:0] rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is fine when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage write; contents are only meaningful while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_wr && !do_rd) begin
        count_q <= count_q + CntW'(1);
      end else if (do_rd && !do_wr) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/gp_cmd_fetch.sv
// Command list fetcher: walks a list in memory on a doorbell, buffers the
// words and streams them to the command decoder until a STOP word.
module gp_cmd_fetch
  import gp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_WORDS  = 4096,
  parameter logic [7:0]  STOP_OP    = STOP_OP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gp_code,
  input  logic [31:0] gp_frame,
  input  logic        gp_valid,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  output logic [31:0] frame_base,
  output logic        busy,
  output logic        err_overrun
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WcW  = $clog2(MAX_WORDS) + 1;
  localparam logic [WcW-1:0]  MaxWordsW = WcW'(MAX_WORDS);
  localparam logic [CntW:0]   DepthW    = (CntW + 1)'(FIFO_DEPTH);

  gp_state_e        state_q, state_d;
  logic [31:0]      ptr_q, ptr_d;
  logic [WcW-1:0]   word_cnt_q, word_cnt_d;
  logic [CntW-1:0]  outst_q, outst_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      pend_addr_q, pend_addr_d;
  logic             stop_seen_q, stop_seen_d;
  logic             err_q, err_d;
  logic [31:0]      frame_q;

  logic [CntW-1:0]  fifo_count;
  logic             fifo_empty;
  logic [31:0]      fifo_head;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [CntW:0]    in_flight;
  logic             req_fire;
  logic             resp_live;
  logic             resp_is_stop;

  // Credit: buffered words plus words still in flight never exceed FIFO_DEPTH,
  // so every response has a guaranteed slot.
  assign in_flight     = {1'b0, fifo_count} + {1'b0, outst_q};
  assign mem_req_valid = (state_q == StFetch) && (in_flight < DepthW) &&
                         (word_cnt_q < MaxWordsW);
  assign mem_req_addr  = ptr_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign resp_live     = mem_resp_valid && (state_q != StIdle);
  assign resp_is_stop  = (cmd_opcode(mem_resp_data) == STOP_OP);
  assign fifo_wr       = resp_live && !stop_seen_q && !resp_is_stop;

  assign cmd_valid     = !fifo_empty;
  assign fifo_rd       = cmd_valid && cmd_ready;
  assign cmd_data      = cmd_valid ? fifo_head : '0;

  assign busy          = (state_q != StIdle);
  assign err_overrun   = err_q;
  assign frame_base    = frame_q;

  gp_cmd_fifo #(
    .Width (32),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (mem_resp_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next-state: list walk, credit accounting, pending doorbell and overrun.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    word_cnt_d   = word_cnt_q;
    outst_d      = outst_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    stop_seen_d  = stop_seen_q;
    err_d        = err_q;

    if (req_fire) begin
      ptr_d      = ptr_q + 32'd4;
      word_cnt_d = word_cnt_q + WcW'(1);
    end

    if (req_fire && !resp_live) begin
      outst_d = outst_q + CntW'(1);
    end else if (!req_fire && resp_live) begin
      outst_d = outst_q - CntW'(1);
    end

    if (resp_live && resp_is_stop) begin
      stop_seen_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // A fresh doorbell overrides an older pending one.
        if (gp_valid || pend_valid_q) begin
          ptr_d        = gp_valid ? word_align(gp_code) : pend_addr_q;
          word_cnt_d   = '0;
          stop_seen_d  = 1'b0;
          pend_valid_d = 1'b0;
          state_d      = StFetch;
        end
      end
      StFetch: begin
        if (resp_live && resp_is_stop) begin
          state_d = StDrain;
        end else if (word_cnt_q == MaxWordsW) begin
          err_d   = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave as the last buffered word is handed over.
        if ((outst_q == '0) &&
            (fifo_empty || ((fifo_count == CntW'(1)) && fifo_rd))) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && gp_valid) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = word_align(gp_code);
    end
  end

  // State registers; frame base tracks any nonzero CPU store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      word_cnt_q   <= '0;
      outst_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      stop_seen_q  <= 1'b0;
      err_q        <= 1'b0;
      frame_q      <= FRAME_RESET_BASE;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_cnt_q   <= word_cnt_d;
      outst_q      <= outst_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      stop_seen_q  <= stop_seen_d;
      err_q        <= err_d;
      if (gp_frame != '0) begin
        frame_q <= gp_frame;
      end
    end
  end

endmodule
